// File: rtl/iwr_pkg.sv
// Shared types and helpers for the activation write controller.
package iwr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREQ,
        PWAIT,
        HOLD,
        WRITE,
        FLUSH,
        LDONE
    } iwr_state_t;

    typedef struct packed {
        logic [7:0] seq_len;
        logic [7:0] in_chan;
    } layer_desc_t;

    localparam int unsigned LANES = 128 / 8;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/iwrite_pingpong_ctrl_act_packer.sv
// Per-row lane register: inserts one activation per beat and emits a zero-filled word.
module act_packer #(
    parameter int unsigned ACT_WIDTH = 8,
    parameter int unsigned LANES     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         beat,
    input  logic                         emit,
    input  logic [$clog2(LANES)-1:0]     lane_sel,
    input  logic [ACT_WIDTH-1:0]         act_in,
    output logic [LANES*ACT_WIDTH-1:0]   word_out
);

    logic [LANES*ACT_WIDTH-1:0] lanes_q;
    logic [LANES*ACT_WIDTH-1:0] word_next;

    always_comb begin
        word_next = lanes_q;
        word_next[lane_sel*ACT_WIDTH +: ACT_WIDTH] = act_in;
    end

    // Clearing after each emit keeps the unfilled upper lanes of a partial word at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q  <= '0;
            word_out <= '0;
        end else if (beat) begin
            if (emit) begin
                word_out <= word_next;
                lanes_q  <= '0;
            end else begin
                lanes_q  <= word_next;
            end
        end
    end

endmodule

// File: rtl/iwrite_pingpong_ctrl.sv
// Activation write controller: descriptor fetch, lane packing and ping/pong IBRAM writes.
module iwrite_pingpong_ctrl
    import iwr_pkg::*;
#(
    parameter int unsigned NUM_ROWS       = 16,
    parameter int unsigned ACT_WIDTH      = 8,
    parameter int unsigned STREAM_WIDTH   = 128,
    parameter int unsigned MAX_IN_CHANNEL = 64,
    parameter int unsigned MAX_SEQ        = 160,
    parameter int unsigned MAX_NUM_LAYERS = 4,
    parameter int unsigned PARAM_WIDTH    = 16,
    parameter int unsigned HALF_DEPTH     = MAX_SEQ * ((MAX_IN_CHANNEL + STREAM_WIDTH/ACT_WIDTH - 1) / (STREAM_WIDTH/ACT_WIDTH)),
    parameter int unsigned ADDR_W         = $clog2(HALF_DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [$clog2(MAX_NUM_LAYERS):0]     num_layers,
    input  logic                                start,
    input  logic [NUM_ROWS*ACT_WIDTH-1:0]       act_data,
    input  logic [NUM_ROWS-1:0]                 act_valid,
    output logic [NUM_ROWS-1:0]                 act_ready,
    output logic [NUM_ROWS*STREAM_WIDTH-1:0]    wr_data,
    output logic [NUM_ROWS-1:0]                 wr_en,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic                                wr_done,
    output logic                                wr_done_half,
    input  logic [1:0]                          full_pp,
    output logic [$clog2(MAX_NUM_LAYERS)-1:0]   param_addr,
    output logic                                param_addr_valid,
    input  logic                                param_addr_ready,
    input  logic [PARAM_WIDTH-1:0]              param_data,
    input  logic                                param_data_valid,
    output logic                                param_data_ready,
    output logic                                busy
);

    localparam int unsigned NLANES  = STREAM_WIDTH / ACT_WIDTH;
    localparam int unsigned LANE_W  = $clog2(NLANES);
    localparam int unsigned LO_W    = ADDR_W - 1;
    localparam int unsigned LAYER_W = $clog2(MAX_NUM_LAYERS) + 1;
    localparam int unsigned PADDR_W = $clog2(MAX_NUM_LAYERS);

    iwr_state_t         state, next_state;
    layer_desc_t        desc_q, desc_eff;
    logic [7:0]         words_q;
    logic [LAYER_W-1:0] layer_cnt, num_layers_q;
    logic               pp_sel;
    logic [LANE_W-1:0]  lane_cnt;
    logic [7:0]         ch_cnt, seq_cnt, word_cnt;
    logic [LO_W-1:0]    seq_base;
    logic               addr_acc, data_beat, beat, last_ch, last_elem, emit, last_layer;

    always_comb begin
        addr_acc   = param_addr_valid & param_addr_ready;
        data_beat  = param_data_ready & param_data_valid;
        desc_eff   = data_beat ? layer_desc_t'(param_data) : desc_q;
        beat       = (state == WRITE) & ~full_pp[pp_sel] & (&act_valid);
        last_ch    = (ch_cnt == desc_q.in_chan - 8'd1);
        last_elem  = last_ch & (seq_cnt == desc_q.seq_len - 8'd1);
        emit       = last_ch | (lane_cnt == LANE_W'(NLANES - 1));
        last_layer = ((layer_cnt + LAYER_W'(1)) == num_layers_q);
        act_ready  = {NUM_ROWS{beat}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start && num_layers != '0) next_state = PREQ;
            // A valid register already low means the address was taken in an earlier cycle.
            PREQ: begin
                if ((~param_addr_valid | addr_acc) & (~param_data_ready | data_beat)) begin
                    if (~param_addr_valid & data_beat)
                        next_state = PWAIT;
                    else if (desc_eff.in_chan == '0 || desc_eff.seq_len == '0)
                        next_state = LDONE;
                    else
                        next_state = HOLD;
                end
            end
            PWAIT: next_state = (desc_q.in_chan == '0 || desc_q.seq_len == '0) ? LDONE : HOLD;
            HOLD:  if (!full_pp[pp_sel]) next_state = WRITE;
            WRITE: if (beat && last_elem) next_state = FLUSH;
            FLUSH: next_state = LDONE;
            LDONE: next_state = last_layer ? IDLE : PREQ;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_q           <= '0;
            words_q          <= '0;
            layer_cnt        <= '0;
            num_layers_q     <= '0;
            pp_sel           <= 1'b0;
            lane_cnt         <= '0;
            ch_cnt           <= '0;
            seq_cnt          <= '0;
            word_cnt         <= '0;
            seq_base         <= '0;
            wr_en            <= '0;
            wr_addr          <= '0;
            wr_done          <= 1'b0;
            wr_done_half     <= 1'b0;
            param_addr       <= '0;
            param_addr_valid <= 1'b0;
            param_data_ready <= 1'b0;
            busy             <= 1'b0;
        end else begin
            wr_en   <= '0;
            wr_done <= 1'b0;
            busy    <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    layer_cnt    <= '0;
                    pp_sel       <= 1'b0;
                    num_layers_q <= num_layers;
                end
                PREQ: begin
                    if (addr_acc) param_addr_valid <= 1'b0;
                    if (data_beat) begin
                        param_data_ready <= 1'b0;
                        desc_q           <= desc_eff;
                        words_q          <= 8'(ceil_div(32'(desc_eff.in_chan), NLANES));
                    end
                end
                // seq_base tracks seq_cnt*words incrementally instead of multiplying.
                WRITE: begin
                    if (beat) begin
                        wr_en <= {NUM_ROWS{emit}};
                        if (emit) wr_addr <= {pp_sel, seq_base + LO_W'(word_cnt)};
                        if (last_ch) begin
                            ch_cnt   <= '0;
                            lane_cnt <= '0;
                            word_cnt <= '0;
                            if (last_elem) begin
                                seq_cnt  <= '0;
                                seq_base <= '0;
                            end else begin
                                seq_cnt  <= seq_cnt + 8'd1;
                                seq_base <= seq_base + LO_W'(words_q);
                            end
                        end else begin
                            ch_cnt   <= ch_cnt + 8'd1;
                            lane_cnt <= lane_cnt + LANE_W'(1);
                            if (emit) word_cnt <= word_cnt + 8'd1;
                        end
                    end
                end
                LDONE: begin
                    pp_sel    <= ~pp_sel;
                    layer_cnt <= layer_cnt + LAYER_W'(1);
                end
                default: ;
            endcase
            if (next_state == PREQ && state != PREQ) begin
                param_addr_valid <= 1'b1;
                param_data_ready <= 1'b1;
                param_addr       <= (state == LDONE) ? PADDR_W'(layer_cnt + LAYER_W'(1)) : '0;
            end
            if (next_state == LDONE && state != LDONE) begin
                wr_done      <= 1'b1;
                wr_done_half <= pp_sel;
            end
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        act_packer #(
            .ACT_WIDTH (ACT_WIDTH),
            .LANES     (NLANES)
        ) u_pack (
            .clk      (clk),
            .rst_n    (rst_n),
            .beat     (beat),
            .emit     (emit),
            .lane_sel (lane_cnt),
            .act_in   (act_data[r*ACT_WIDTH +: ACT_WIDTH]),
            .word_out (wr_data[r*STREAM_WIDTH +: STREAM_WIDTH])
        );
    end

endmodule
